// File: rtl/phase_sequencer.sv
// Four-phase run sequencer that feeds a down-counting timer.
// It supports one-shot and looping runs, abort, and a saturating count of completed rounds.
module phase_sequencer #(
  parameter int N  = 4,
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          loop_en,
  input  logic [N-1:0]  dur0,
  input  logic [N-1:0]  dur1,
  input  logic [N-1:0]  dur2,
  input  logic [N-1:0]  dur3,
  input  logic          timer_done,
  output logic          timer_load,
  output logic [N-1:0]  timer_in,
  output logic [1:0]    phase,
  output logic          busy,
  output logic          seq_done,
  output logic [RW-1:0] rounds
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [1:0] LAST_PHASE = 2'd3;

  state_t        state_q;
  logic [1:0]    phase_q;
  logic [N-1:0]  dur_q [4];
  logic [RW-1:0] rounds_q;
  logic          seq_done_q;

  // NOTE: every register in this block, including the small duration array, is reset.
  // This keeps timer_in at 0 after reset instead of showing stale or X data.
  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      rounds_q   <= '0;
      seq_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) dur_q[i] <= '0;
    end else begin
      seq_done_q <= 1'b0;
      if (abort) begin
        // rounds is deliberately left alone so the count survives an abort.
        state_q <= IDLE;
        phase_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              dur_q[0] <= dur0;
              dur_q[1] <= dur1;
              dur_q[2] <= dur2;
              dur_q[3] <= dur3;
              phase_q  <= '0;
              rounds_q <= '0;
              state_q  <= LOAD;
            end
          end
          LOAD: state_q <= WAIT;
          WAIT: begin
            if (timer_done) begin
              if (phase_q != LAST_PHASE) begin
                phase_q <= phase_q + 2'd1;
                state_q <= LOAD;
              end else begin
                phase_q <= '0;
                if (rounds_q != '1) rounds_q <= rounds_q + RW'(1);
                if (loop_en) begin
                  state_q <= LOAD;
                end else begin
                  state_q    <= IDLE;
                  seq_done_q <= 1'b1;
                end
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign timer_load = (state_q == LOAD);
  assign timer_in   = dur_q[phase_q];
  assign busy       = (state_q != IDLE);
  assign phase      = phase_q;
  assign seq_done   = seq_done_q;
  assign rounds     = rounds_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer. Each DUT drives a simple down-counting timer model.
// A second instance with RW=2 exercises saturation of the rounds counter.
module tb_phase_sequencer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst, start, abort, loop_en;
  logic [N-1:0] dur0, dur1, dur2, dur3;
  logic         timer_done, timer_load, busy, seq_done;
  logic [N-1:0] timer_in;
  logic [1:0]   phase;
  logic [7:0]   rounds;
  logic [N-1:0] cnt;

  logic         start_s, loop_s;
  logic [N-1:0] zero_dur;
  logic         timer_done_s, timer_load_s, busy_s, seq_done_s;
  logic [N-1:0] timer_in_s;
  logic [1:0]   phase_s;
  logic [1:0]   rounds_s;
  logic [N-1:0] cnt_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  phase_sequencer #(.N(N), .RW(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
    .dur0(dur0), .dur1(dur1), .dur2(dur2), .dur3(dur3),
    .timer_done(timer_done), .timer_load(timer_load), .timer_in(timer_in),
    .phase(phase), .busy(busy), .seq_done(seq_done), .rounds(rounds)
  );

  phase_sequencer #(.N(N), .RW(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .abort(1'b0), .loop_en(loop_s),
    .dur0(zero_dur), .dur1(zero_dur), .dur2(zero_dur), .dur3(zero_dur),
    .timer_done(timer_done_s), .timer_load(timer_load_s), .timer_in(timer_in_s),
    .phase(phase_s), .busy(busy_s), .seq_done(seq_done_s), .rounds(rounds_s)
  );

  // Timer model: loads on timer_load, counts down to 0 and holds, done while the count is 0.
  always @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (timer_load) cnt <= timer_in;
    else if (cnt != '0) cnt <= cnt - 4'd1;
  end
  assign timer_done = (cnt == '0);

  always @(posedge clk) begin
    if (rst) cnt_s <= '0;
    else if (timer_load_s) cnt_s <= timer_in_s;
    else if (cnt_s != '0) cnt_s <= cnt_s - 4'd1;
  end
  assign timer_done_s = (cnt_s == '0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int exp_ph;
    int exp_ld;
    int exp_in;
    int exp_rd;

    rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
    dur0 = '0; dur1 = '0; dur2 = '0; dur3 = '0;
    start_s = 1'b0; loop_s = 1'b0; zero_dur = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_load", 32'(timer_load), 32'd0);
    check("rst_tin", 32'(timer_in), 32'd0);
    check("rst_rounds", 32'(rounds), 32'd0);
    rst = 1'b0;
    tick();

    // One-shot run with durations 2,0,3,1. A stray start and a duration change arrive mid-run.
    dur0 = 4'd2; dur1 = 4'd0; dur2 = 4'd3; dur3 = 4'd1; loop_en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      exp_ph = (c <= 4) ? 0 : (c <= 6) ? 1 : (c <= 11) ? 2 : 3;
      exp_ld = (c == 1 || c == 5 || c == 7 || c == 12) ? 1 : 0;
      exp_in = (c == 1) ? 2 : (c == 5) ? 0 : (c == 7) ? 3 : 1;
      check($sformatf("os_busy_c%0d", c), 32'(busy), 32'd1);
      check($sformatf("os_phase_c%0d", c), 32'(phase), 32'(exp_ph));
      check($sformatf("os_load_c%0d", c), 32'(timer_load), 32'(exp_ld));
      check($sformatf("os_sdone_c%0d", c), 32'(seq_done), 32'd0);
      if (exp_ld == 1) check($sformatf("os_tin_c%0d", c), 32'(timer_in), 32'(exp_in));
      if (c == 1) begin dur0 = 4'd7; dur1 = 4'd7; dur2 = 4'd7; dur3 = 4'd7; end
      start = (c == 8);
      tick();
    end
    check("os_end_busy", 32'(busy), 32'd0);
    check("os_end_sdone", 32'(seq_done), 32'd1);
    check("os_end_rounds", 32'(rounds), 32'd1);
    check("os_end_phase", 32'(phase), 32'd0);
    tick();
    check("os_sdone_pulse", 32'(seq_done), 32'd0);

    // Looping run with all durations 1: 3 cycles per phase and 12 per round. Looping is released at cycle 40.
    dur0 = 4'd1; dur1 = 4'd1; dur2 = 4'd1; dur3 = 4'd1; loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 48; c++) begin
      check($sformatf("lp_phase_c%0d", c), 32'(phase), 32'(((c - 1) / 3) % 4));
      check($sformatf("lp_rounds_c%0d", c), 32'(rounds), 32'((c - 1) / 12));
      check($sformatf("lp_busy_c%0d", c), 32'(busy), 32'd1);
      check($sformatf("lp_sdone_c%0d", c), 32'(seq_done), 32'd0);
      if (c == 40) loop_en = 1'b0;
      tick();
    end
    check("lp_end_busy", 32'(busy), 32'd0);
    check("lp_end_sdone", 32'(seq_done), 32'd1);
    check("lp_end_rounds", 32'(rounds), 32'd4);

    // Abort during the WAIT of phase 1 in the second round (durations 0,1,0,0, 9 cycles per round).
    tick();
    dur0 = 4'd0; dur1 = 4'd1; dur2 = 4'd0; dur3 = 4'd0; loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 13; c++) tick();
    check("ab_pre_phase", 32'(phase), 32'd1);
    check("ab_pre_load", 32'(timer_load), 32'd0);
    check("ab_pre_rounds", 32'(rounds), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_phase", 32'(phase), 32'd0);
    check("ab_rounds", 32'(rounds), 32'd1);
    check("ab_sdone", 32'(seq_done), 32'd0);
    tick();
    check("ab_sdone2", 32'(seq_done), 32'd0);
    check("ab_idle2", 32'(busy), 32'd0);
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("sa_busy", 32'(busy), 32'd0);
    check("sa_load", 32'(timer_load), 32'd0);
    check("sa_rounds", 32'(rounds), 32'd1);
    tick();
    check("sa_busy2", 32'(busy), 32'd0);

    // Saturation with RW=2: all durations are 0, so each round takes 8 cycles and rounds caps at 3.
    loop_s = 1'b1; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      exp_rd = ((c - 1) / 8 > 3) ? 3 : (c - 1) / 8;
      check($sformatf("sat_rounds_c%0d", c), 32'(rounds_s), 32'(exp_rd));
      check($sformatf("sat_phase_c%0d", c), 32'(phase_s), 32'(((c - 1) / 2) % 4));
      check($sformatf("sat_busy_c%0d", c), 32'(busy_s), 32'd1);
      tick();
    end

    // Hold rst high for two edges mid-run, at phase 2 of the second round.
    dur0 = 4'd1; dur1 = 4'd1; dur2 = 4'd1; dur3 = 4'd1; loop_en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    check("mr_pre_phase", 32'(phase), 32'd2);
    check("mr_pre_rounds", 32'(rounds), 32'd1);
    rst = 1'b1;
    tick();
    tick();
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_phase", 32'(phase), 32'd0);
    check("mr_load", 32'(timer_load), 32'd0);
    check("mr_tin", 32'(timer_in), 32'd0);
    check("mr_sdone", 32'(seq_done), 32'd0);
    check("mr_rounds", 32'(rounds), 32'd0);
    check("mr_sat_rounds", 32'(rounds_s), 32'd0);
    check("mr_sat_busy", 32'(busy_s), 32'd0);
    rst = 1'b0;
    tick();
    check("mr_after_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
